// File: rtl/wisc_mem_pkg.sv
// Shared types and default geometry for the main-memory arbiter and its fill sequencer.
// The block geometry sets how a byte address splits into block base, word index and byte offset.
package wisc_mem_pkg;

    localparam int WORDS_PER_BLK = 8;
    localparam int MEM_LAT       = 4;
    localparam int WORD_IDX_W    = $clog2(WORDS_PER_BLK);
    localparam int BYTE_OFF_W    = 1;
    localparam int BLK_OFF_W     = WORD_IDX_W + BYTE_OFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_fill_seq.sv
// Issue/receive counter pair for one block fill.
// Both counters are held at zero whenever the sequencer is not enabled.
module mem_fill_seq #(
    parameter int WORDS_PER_BLK = wisc_mem_pkg::WORDS_PER_BLK
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             mem_valid,
    output logic                             issue_active,
    output logic                             fill_accept,
    output logic                             last_word,
    output logic [$clog2(WORDS_PER_BLK)-1:0] iss_word,
    output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word
);

    localparam int IDX_W = $clog2(WORDS_PER_BLK);
    localparam int CNT_W = IDX_W + 1;

    logic [CNT_W-1:0] iss;
    logic [IDX_W-1:0] rcv;

    assign issue_active = en && (iss < CNT_W'(WORDS_PER_BLK));
    // A return is only taken while a read is outstanding, so stray strobes cannot advance rcv.
    assign fill_accept  = en && mem_valid && ({1'b0, rcv} < iss);
    assign last_word    = fill_accept && (rcv == IDX_W'(WORDS_PER_BLK - 1));
    assign iss_word     = iss[IDX_W-1:0];
    assign fill_word    = rcv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss <= '0;
        end else if (!en) begin
            iss <= '0;
        end else if (issue_active) begin
            iss <= iss + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcv <= '0;
        end else if (!en || last_word) begin
            rcv <= '0;
        end else if (fill_accept) begin
            rcv <= rcv + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter: grants stores and I/D block fills one at a time,
// issues the block's word reads and steers returned words into the owning cache.
module mem_arbiter
    import wisc_mem_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = wisc_mem_pkg::WORDS_PER_BLK,
    parameter int MEM_LAT       = wisc_mem_pkg::MEM_LAT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ic_miss,
    input  logic [ADDR_W-1:0]                ic_miss_addr,
    input  logic                             dc_miss,
    input  logic [ADDR_W-1:0]                dc_miss_addr,
    input  logic                             dc_wr_req,
    input  logic [ADDR_W-1:0]                dc_wr_addr,
    input  logic [DATA_W-1:0]                dc_wr_data,
    output logic                             mem_en,
    output logic                             mem_wr,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata,
    input  logic                             mem_valid,
    output logic [DATA_W-1:0]                fill_data,
    output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word,
    output logic                             ic_fill_we,
    output logic                             dc_fill_we,
    output logic                             ic_fill_done,
    output logic                             dc_fill_done,
    output logic                             dc_wr_done,
    output logic                             busy
);

    localparam int IDX_W  = $clog2(WORDS_PER_BLK);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int OFF_W  = IDX_W + BYTE_W;
    localparam int BASE_W = ADDR_W - OFF_W;

    // The latency never enters the logic (returns are counted, not timed); only sanity-check it.
    if (WORDS_PER_BLK < 2 || MEM_LAT < 1) begin : g_cfg_check
        $error("mem_arbiter: unsupported block size or memory latency");
    end

    state_t            state, state_next;
    owner_t            owner_q, owner_d;
    logic [BASE_W-1:0] base_q, base_d;

    logic              seq_en;
    logic              issue_active;
    logic              fill_accept;
    logic              last_word;
    logic [IDX_W-1:0]  iss_word;
    logic [IDX_W-1:0]  rcv_word;

    logic              unused_offsets;
    assign unused_offsets = ^{ic_miss_addr[OFF_W-1:0], dc_miss_addr[OFF_W-1:0]};

    assign seq_en = (state == FILL);
    assign busy   = (state != IDLE);

    mem_fill_seq #(
        .WORDS_PER_BLK (WORDS_PER_BLK)
    ) u_fill_seq (
        .clk          (clk),
        .rst          (rst),
        .en           (seq_en),
        .mem_valid    (mem_valid),
        .issue_active (issue_active),
        .fill_accept  (fill_accept),
        .last_word    (last_word),
        .iss_word     (iss_word),
        .fill_word    (rcv_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner_q <= OWN_DC;
            base_q  <= '0;
        end else begin
            state   <= state_next;
            owner_q <= owner_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_next   = state;
        owner_d      = owner_q;
        base_d       = base_q;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fill_data    = '0;
        fill_word    = '0;
        ic_fill_we   = 1'b0;
        dc_fill_we   = 1'b0;
        ic_fill_done = 1'b0;
        dc_fill_done = 1'b0;
        dc_wr_done   = 1'b0;

        unique case (state)
            IDLE: begin
                // Stores first so write-through data never sits behind a whole block fill.
                if (dc_wr_req) begin
                    state_next = WRITE;
                end else if (dc_miss) begin
                    state_next = FILL;
                    owner_d    = OWN_DC;
                    base_d     = dc_miss_addr[ADDR_W-1:OFF_W];
                end else if (ic_miss) begin
                    state_next = FILL;
                    owner_d    = OWN_IC;
                    base_d     = ic_miss_addr[ADDR_W-1:OFF_W];
                end
            end

            WRITE: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = dc_wr_addr;
                mem_wdata  = dc_wr_data;
                dc_wr_done = 1'b1;
                state_next = IDLE;
            end

            FILL: begin
                if (issue_active) begin
                    mem_en   = 1'b1;
                    mem_addr = {base_q, iss_word, {BYTE_W{1'b0}}};
                end
                if (fill_accept) begin
                    fill_data  = mem_rdata;
                    fill_word  = rcv_word;
                    ic_fill_we = (owner_q == OWN_IC);
                    dc_fill_we = (owner_q == OWN_DC);
                end
                if (last_word) begin
                    ic_fill_done = (owner_q == OWN_IC);
                    dc_fill_done = (owner_q == OWN_DC);
                    state_next   = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-accurate memory model plus ordered queues of expected
// bus issues and cache fills, with per-scenario timing checks.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_miss = 1'b0;
    logic [15:0] ic_miss_addr = '0;
    logic        dc_miss = 1'b0;
    logic [15:0] dc_miss_addr = '0;
    logic        dc_wr_req = 1'b0;
    logic [15:0] dc_wr_addr = '0;
    logic [15:0] dc_wr_data = '0;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        ic_fill_we;
    logic        dc_fill_we;
    logic        ic_fill_done;
    logic        dc_fill_done;
    logic        dc_wr_done;
    logic        busy;

    int total = 0;
    int bad = 0;

    // {wr, addr, wdata} per bus access; {ic_we, dc_we, word, data} per fill beat.
    logic [32:0] exp_q[$];
    logic [20:0] exp_fill_q[$];
    logic [32:0] e_mem;
    logic [20:0] e_fill;

    logic [15:0]        data_base = '0;
    logic               force_v = 1'b0;
    logic [MEM_LAT-1:0] pv = '0;
    logic [15:0]        pd [MEM_LAT];

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .ic_miss      (ic_miss),
        .ic_miss_addr (ic_miss_addr),
        .dc_miss      (dc_miss),
        .dc_miss_addr (dc_miss_addr),
        .dc_wr_req    (dc_wr_req),
        .dc_wr_addr   (dc_wr_addr),
        .dc_wr_data   (dc_wr_data),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid),
        .fill_data    (fill_data),
        .fill_word    (fill_word),
        .ic_fill_we   (ic_fill_we),
        .dc_fill_we   (dc_fill_we),
        .ic_fill_done (ic_fill_done),
        .dc_fill_done (dc_fill_done),
        .dc_wr_done   (dc_wr_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Memory: a read sampled at a rising edge returns MEM_LAT cycles after its issue cycle.
    always @(posedge clk) begin
        pv    <= {pv[MEM_LAT-2:0], mem_en & ~mem_wr};
        pd[0] <= data_base + {13'd0, mem_addr[3:1]};
        for (int i = 1; i < MEM_LAT; i++) pd[i] <= pd[i-1];
    end
    assign mem_valid = pv[MEM_LAT-1] | force_v;
    assign mem_rdata = force_v ? 16'hDEAD : pd[MEM_LAT-1];

    // Scoreboard: every bus access and fill beat must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL mem_issue_extra: got wr=%0b addr=%h wdata=%h, required no access", mem_wr, mem_addr, mem_wdata);
                end else begin
                    e_mem = exp_q.pop_front();
                    if ({mem_wr, mem_addr, mem_wdata} !== e_mem) begin
                        bad++;
                        $display("FAIL mem_issue: got wr=%0b addr=%h wdata=%h, required wr=%0b addr=%h wdata=%h",
                                 mem_wr, mem_addr, mem_wdata, e_mem[32], e_mem[31:16], e_mem[15:0]);
                    end
                end
                total++;
                if (dc_wr_done !== mem_wr) begin
                    bad++;
                    $display("FAIL wr_done_pulse: got %0b, required %0b", dc_wr_done, mem_wr);
                end
            end else if (mem_wr !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0 || dc_wr_done !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL idle_bus: got wr=%0b addr=%h wdata=%h wr_done=%0b, required all 0", mem_wr, mem_addr, mem_wdata, dc_wr_done);
            end

            if (ic_fill_we || dc_fill_we) begin
                total++;
                if (exp_fill_q.size() == 0) begin
                    bad++;
                    $display("FAIL fill_extra: got ic_we=%0b dc_we=%0b word=%0d data=%h, required no fill", ic_fill_we, dc_fill_we, fill_word, fill_data);
                end else begin
                    e_fill = exp_fill_q.pop_front();
                    if ({ic_fill_we, dc_fill_we, fill_word, fill_data} !== e_fill) begin
                        bad++;
                        $display("FAIL fill_beat: got ic_we=%0b dc_we=%0b word=%0d data=%h, required ic_we=%0b dc_we=%0b word=%0d data=%h",
                                 ic_fill_we, dc_fill_we, fill_word, fill_data, e_fill[20], e_fill[19], e_fill[18:16], e_fill[15:0]);
                    end
                    total++;
                    if ({ic_fill_done, dc_fill_done} !== ({e_fill[20], e_fill[19]} & {2{e_fill[18:16] == 3'd7}})) begin
                        bad++;
                        $display("FAIL fill_done: got ic=%0b dc=%0b at word %0d, required pulse only on word 7", ic_fill_done, dc_fill_done, fill_word);
                    end
                end
            end else if (ic_fill_done || dc_fill_done || fill_data !== 16'h0 || fill_word !== 3'd0) begin
                total++;
                bad++;
                $display("FAIL idle_fill: got done=%0b%0b word=%0d data=%h, required all 0", ic_fill_done, dc_fill_done, fill_word, fill_data);
            end
        end
    end

    task automatic push_fill(input bit is_ic, input logic [15:0] base, input logic [15:0] dbase, input int nissue, input int nfill);
        for (int k = 0; k < nissue; k++) exp_q.push_back({1'b0, base + 16'(2 * k), 16'h0000});
        for (int k = 0; k < nfill; k++) exp_fill_q.push_back({is_ic, ~is_ic, 3'(k), dbase + 16'(k)});
    endtask

    task automatic wait_done(input bit want_ic, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (want_ic ? ic_fill_done : dc_fill_done) break;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata} !== 34'h0) begin
            bad++;
            $display("FAIL reset_bus: got en=%0b wr=%0b addr=%h wdata=%h, required 0", mem_en, mem_wr, mem_addr, mem_wdata);
        end
        total++;
        if ({fill_data, fill_word, ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_done, busy} !== 25'h0) begin
            bad++;
            $display("FAIL reset_fill: got data=%h word=%0d we=%0b%0b done=%0b%0b wr_done=%0b busy=%0b, required 0",
                     fill_data, fill_word, ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_done, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_ic_fill();
        int n;
        data_base = 16'h00A0;
        push_fill(1'b1, 16'h1230, 16'h00A0, 8, 8);
        @(posedge clk); #1;
        ic_miss = 1'b1; ic_miss_addr = 16'h1234;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL ic_request_cycle: got busy=%0b mem_en=%0b, required 0 0", busy, mem_en);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || mem_en !== 1'b1) begin
            bad++;
            $display("FAIL ic_first_issue: got busy=%0b mem_en=%0b, required 1 1", busy, mem_en);
        end
        wait_done(1'b1, 20, n);
        total++;
        if (n !== 11) begin
            bad++;
            $display("FAIL ic_done_latency: got T+%0d, required T+12", n + 1);
        end
        @(posedge clk); #1;
        ic_miss = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ic_idle_after: got busy=%0b at T+13, required 0", busy);
        end
    endtask

    task automatic test_dc_ic_order();
        int n;
        data_base = 16'h3300;
        push_fill(1'b0, 16'h0040, 16'h3300, 8, 8);
        push_fill(1'b1, 16'h2000, 16'h3300, 8, 8);
        @(posedge clk); #1;
        dc_miss = 1'b1; dc_miss_addr = 16'h0040;
        ic_miss = 1'b1; ic_miss_addr = 16'h2000;
        @(negedge clk);
        wait_done(1'b0, 20, n);
        total++;
        if (n !== 12) begin
            bad++;
            $display("FAIL dc_first_done: got T+%0d, required T+12", n);
        end
        @(posedge clk); #1;
        dc_miss = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL arb_idle_gap: got busy=%0b, required 0", busy);
        end
        @(negedge clk);
        total++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h2000) begin
            bad++;
            $display("FAIL ic_after_dc: got en=%0b addr=%h, required 1 2000", mem_en, mem_addr);
        end
        wait_done(1'b1, 20, n);
        total++;
        if (n !== 11) begin
            bad++;
            $display("FAIL ic_second_done: got %0d cycles after first issue, required 11", n);
        end
        @(posedge clk); #1;
        ic_miss = 1'b0;
    endtask

    task automatic test_write_then_fill();
        int n;
        data_base = 16'h5500;
        exp_q.push_back({1'b1, 16'h0100, 16'hBEEF});
        push_fill(1'b0, 16'h0340, 16'h5500, 8, 8);
        @(posedge clk); #1;
        dc_wr_req = 1'b1; dc_wr_addr = 16'h0100; dc_wr_data = 16'hBEEF;
        dc_miss = 1'b1; dc_miss_addr = 16'h0346;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (dc_wr_done !== 1'b1 || mem_wr !== 1'b1) begin
            bad++;
            $display("FAIL write_cycle: got wr_done=%0b mem_wr=%0b at T+1, required 1 1", dc_wr_done, mem_wr);
        end
        @(posedge clk); #1;
        dc_wr_req = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL write_idle: got busy=%0b at T+2, required 0", busy);
        end
        @(negedge clk);
        total++;
        if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0340) begin
            bad++;
            $display("FAIL fill_after_write: got en=%0b wr=%0b addr=%h at T+3, required 1 0 0340", mem_en, mem_wr, mem_addr);
        end
        wait_done(1'b0, 20, n);
        total++;
        if (n !== 11) begin
            bad++;
            $display("FAIL write_fill_done: got T+%0d, required T+14", n + 3);
        end
        @(posedge clk); #1;
        dc_miss = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        int n;
        data_base = 16'h7700;
        push_fill(1'b1, 16'h0A10, 16'h7700, 5, 1);
        @(posedge clk); #1;
        ic_miss = 1'b1; ic_miss_addr = 16'h0A10;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; ic_miss = 1'b0;
        #1;
        total++;
        if ({mem_en, busy, ic_fill_we, ic_fill_done} !== 4'b0) begin
            bad++;
            $display("FAIL reset_mid_fill: got en=%0b busy=%0b we=%0b done=%0b, required 0", mem_en, busy, ic_fill_we, ic_fill_done);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ic_fill_we !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stale_return: got we=%0b busy=%0b, required 0 0", ic_fill_we, busy);
        end
        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() !== 0 || exp_fill_q.size() !== 0) begin
            bad++;
            $display("FAIL pre_reset_beats: got %0d issues %0d fills outstanding, required 0 0", exp_q.size(), exp_fill_q.size());
        end
        data_base = 16'h7800;
        push_fill(1'b1, 16'h0A10, 16'h7800, 8, 8);
        @(posedge clk); #1;
        ic_miss = 1'b1;
        @(negedge clk);
        wait_done(1'b1, 20, n);
        total++;
        if (n !== 12) begin
            bad++;
            $display("FAIL restart_done: got T+%0d, required T+12", n);
        end
        @(posedge clk); #1;
        ic_miss = 1'b0;
    endtask

    task automatic test_idle_valid_and_drop();
        data_base = 16'h1100;
        @(posedge clk); #1;
        force_v = 1'b1;
        @(negedge clk);
        total++;
        if ({ic_fill_we, dc_fill_we, busy} !== 3'b0 || fill_data !== 16'h0) begin
            bad++;
            $display("FAIL idle_valid: got we=%0b%0b busy=%0b data=%h, required 0", ic_fill_we, dc_fill_we, busy, fill_data);
        end
        @(posedge clk); #1;
        force_v = 1'b0;
        push_fill(1'b1, 16'h0F00, 16'h1100, 8, 8);
        ic_miss = 1'b1; ic_miss_addr = 16'h0F0E;
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 3) ic_miss = 1'b0;
            @(negedge clk);
            if (k == 12) begin
                total++;
                if (ic_fill_done !== 1'b1) begin
                    bad++;
                    $display("FAIL dropped_req_done: got %0b at T+12, required 1", ic_fill_done);
                end
            end
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL dropped_req_idle: got busy=%0b at T+13, required 0", busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ic_fill();
        test_dc_ic_order();
        test_write_then_fill();
        test_reset_mid_fill();
        test_idle_valid_and_drop();
        repeat (8) @(negedge clk);
        total++;
        if (exp_q.size() !== 0 || exp_fill_q.size() !== 0) begin
            bad++;
            $display("FAIL final_drain: got %0d issues %0d fills outstanding, required 0 0", exp_q.size(), exp_fill_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port main-memory arbiter and cache-fill sequencer for the pipelined core. Sits between the I-cache miss path, the D-cache miss/store path and the one shared multi-cycle main memory: it grants the memory to one requester at a time, issues the 8 word reads of a block fill, and streams the returned words into the owning cache. The pipeline hazard logic sees it only through the per-cache `*_fill_done` pulses and the `busy` flag, which together drive the stall and release decisions.

## Interface
- `ADDR_W`, 16, byte address width
- `DATA_W`, 16, memory word width
- `WORDS_PER_BLK`, 8, words per cache block (power of two)
- `MEM_LAT`, 4, cycles from read issue to `mem_valid`
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ic_miss`  in  1  I-cache miss, level, held until `ic_fill_done`
- `ic_miss_addr`  in  ADDR_W  I-cache miss byte address
- `dc_miss`  in  1  D-cache miss, level, held until `dc_fill_done`
- `dc_miss_addr`  in  ADDR_W  D-cache miss byte address
- `dc_wr_req`  in  1  D-cache write-through store, level, held until `dc_wr_done`
- `dc_wr_addr`  in  ADDR_W  store byte address
- `dc_wr_data`  in  DATA_W  store data
- `mem_en`  out  1  memory access strobe
- `mem_wr`  out  1  1 = write, 0 = read
- `mem_addr`  out  ADDR_W  memory byte address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `mem_valid`  in  1  `mem_rdata` valid
- `fill_data`  out  DATA_W  word being filled (= `mem_rdata`)
- `fill_word`  out  log2(WORDS_PER_BLK)  word index within the block
- `ic_fill_we`, `dc_fill_we`  out  1  write enable into the owning cache data array
- `ic_fill_done`, `dc_fill_done`  out  1  one-cycle pulse on the last fill word
- `dc_wr_done`  out  1  one-cycle pulse when the store is issued
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, WRITE, FILL.
- IDLE priority: `dc_wr_req` > `dc_miss` > `ic_miss`.
  - A request selects WRITE or FILL for the next cycle.
  - On entry to FILL, latch the owner and block base `addr[ADDR_W-1:4]`.
  - Nothing is issued in IDLE.
- WRITE (one cycle):
  - `mem_en`=1, `mem_wr`=1, `mem_addr`=`dc_wr_addr`, `mem_wdata`=`dc_wr_data`.
  - `dc_wr_done`=1; next state is IDLE.
- FILL:
  - Issue counter `iss` runs 0..7. While `iss` < 8: `mem_en`=1, `mem_wr`=0, `mem_addr`={base, iss[2:0], 1'b0}, then `iss` increments.
  - Receive counter `rcv` increments on each `mem_valid`. In that cycle: owner's `*_fill_we`=1, `fill_word`=`rcv`, `fill_data`=`mem_rdata`.
  - When `rcv`==7 and `mem_valid`: owner's `*_fill_done`=1 and next state is IDLE.
  - Both counters clear on FILL exit.
- All `mem_*`, `fill_*` and `*_done` outputs are combinational from state, counters and `mem_valid`.
  - They are 0 outside their state; `mem_addr`/`mem_wdata` are 0 when `mem_en`=0.
- Boundaries:
  - `mem_valid` outside FILL, or after the 8th word, is ignored.
  - A requester dropping its request mid-fill does not abort the fill; it completes and `done` still pulses.
  - Requests arriving during WRITE or FILL wait; they are evaluated in the next IDLE cycle.
  - Simultaneous `dc_miss` and `ic_miss`: D-cache is filled first; the I-cache is granted in the IDLE cycle after `dc_fill_done`.
  - `rst` mid-fill: immediate IDLE, counters 0, no `done` pulse; in-flight `mem_valid` returns are dropped.
- Reset values: state IDLE, `iss`=0, `rcv`=0, owner D-cache, base 0. Every output is 0.

## Timing
- Request seen in IDLE at cycle T: WRITE or FILL starts at T+1.
- Store: `dc_wr_done` at T+1; IDLE at T+2.
- Fill:
  - Reads issued T+1..T+8.
  - Data returns T+1+MEM_LAT .. T+8+MEM_LAT (T+5..T+12).
  - `*_fill_done` at T+12; IDLE at T+13; earliest next grant decision at T+13.
- Fill throughput is 12 busy cycles per block, plus 1 IDLE arbitration cycle.

## Structure
- Shared package `wisc_mem_pkg` holds:
  - state enum {IDLE, WRITE, FILL}
  - owner enum {OWN_IC, OWN_DC}
  - `WORDS_PER_BLK` and `MEM_LAT` constants
  - block-offset field widths
- One sub-module, `mem_fill_seq`: the issue/receive counter pair with `issue_active`, `last_word` and `fill_word` outputs, enabled by the FILL state. The FSM and arbitration stay in `mem_arbiter`.

## Test plan
- `ic_miss`=1 with `ic_miss_addr`=0x1234 → reads to 0x1230, 0x1232 … 0x123E at T+1..T+8; returned words 0xA0..0xA7 appear on `fill_data` with `ic_fill_we` and `fill_word` 0..7 at T+5..T+12; `ic_fill_done` at T+12; `busy` low at T+13.
- `dc_miss` (0x0040) and `ic_miss` (0x2000) asserted in the same cycle → D-cache fill of 0x0040..0x004E completes first; the I-cache fill issues 0x2000 starting the cycle after IDLE is re-entered; no cross-assertion of `*_fill_we`.
- `dc_wr_req` with addr 0x0100, data 0xBEEF, together with `dc_miss` → one write cycle with `mem_wr`=1 and `dc_wr_done` at T+1, then the fill begins at T+3.
- `rst` asserted at the 6th issue cycle of a fill → outputs 0 immediately; later `mem_valid` pulses produce no `fill_we`; a new `ic_miss` after reset release restarts the fill at word 0.
- `mem_valid` pulsed while IDLE, and `ic_miss` dropped mid-fill → IDLE pulse ignored; the fill still delivers all 8 words and `ic_fill_done`.
